// File: rtl/rv_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
package rv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_ALU,
        CL_ILLEGAL
    } op_class_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_TIMEOUT = 2'd2
    } trap_cause_t;

endpackage

// File: rtl/rv_op_classify.sv
// Maps the opcode field of the instruction register onto a sequencing class.
module rv_op_classify
    import rv_seq_pkg::*;
(
    input  logic [6:0] i_op,
    output op_class_t  o_class
);

    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_op)
            OP_LOAD:   o_class = CL_LOAD;
            OP_STORE:  o_class = CL_STORE;
            OP_BRANCH: o_class = CL_BRANCH;
            OP_JAL,
            OP_JALR:   o_class = CL_JUMP;
            OP_OP,
            OP_OPIMM,
            OP_LUI,
            OP_AUIPC:  o_class = CL_ALU;
            default:   o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: commit strobes, memory handshake, counters and traps.
module multicycle_sequencer
    import rv_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       ir_op,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    state_t            w_boundary;
    trap_cause_t       r_trapCause;
    trap_cause_t       w_trapCode;
    logic              r_halted;
    logic              w_trapSet;
    logic              w_retire;
    logic              w_waitExpired;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0]  r_cycleCnt;
    logic [CNT_W-1:0]  r_instretCnt;
    op_class_t         w_class;

    rv_op_classify u_classify (
        .i_op    (ir_op),
        .o_class (w_class)
    );

    assign w_boundary    = run ? ST_FETCH : ST_IDLE;
    assign w_waitExpired = !mem_ready && (r_waitCnt == WAIT_LAST);

    always_comb begin
        w_next       = r_state;
        w_trapSet    = 1'b0;
        w_trapCode   = TRAP_NONE;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        reg_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = ST_DECODE;
                end else if (w_waitExpired) begin
                    w_trapSet  = 1'b1;
                    w_trapCode = TRAP_TIMEOUT;
                    w_next     = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (w_class == CL_ILLEGAL) begin
                    w_trapSet  = 1'b1;
                    w_trapCode = TRAP_ILLEGAL;
                    w_next     = ST_TRAP;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_class)
                    CL_LOAD, CL_STORE: w_next = ST_MEM;
                    CL_BRANCH: begin
                        pc_we    = 1'b1;
                        pc_sel   = br_taken;
                        w_retire = 1'b1;
                        w_next   = w_boundary;
                    end
                    default: w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_class == CL_STORE);
                if (mem_ready) begin
                    if (w_class == CL_STORE) begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                        w_next   = w_boundary;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_waitExpired) begin
                    w_trapSet  = 1'b1;
                    w_trapCode = TRAP_TIMEOUT;
                    w_next     = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we   = 1'b1;
                pc_we    = 1'b1;
                pc_sel   = (w_class == CL_JUMP);
                w_retire = 1'b1;
                w_next   = w_boundary;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_IDLE;
        endcase
    end

    // Wait counter restarts on every state change, so it counts only consecutive stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_trapCause  <= TRAP_NONE;
            r_halted     <= 1'b0;
            r_waitCnt    <= '0;
            r_cycleCnt   <= '0;
            r_instretCnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_trapSet) begin
                r_trapCause <= w_trapCode;
                r_halted    <= 1'b1;
            end
            if (w_next != r_state) begin
                r_waitCnt <= '0;
            end else if ((r_state == ST_FETCH || r_state == ST_MEM) && !mem_ready) begin
                r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
            if (r_state != ST_IDLE && r_state != ST_TRAP) begin
                r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            end
            if (w_retire) begin
                r_instretCnt <= r_instretCnt + CNT_W'(1);
            end
        end
    end

    assign state_o     = r_state;
    assign halted      = r_halted;
    assign trap_cause  = r_trapCause;
    assign cycle_cnt   = r_cycleCnt;
    assign instret_cnt = r_instretCnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for multicycle_sequencer with a short memory timeout.
module tb_multicycle_sequencer;

    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] BAD   = 7'h7F;

    // Strobe vector bits: {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we}
    localparam logic [6:0] S_REQ   = 7'b1000000;
    localparam logic [6:0] S_WE    = 7'b0100000;
    localparam logic [6:0] S_ASEL  = 7'b0010000;
    localparam logic [6:0] S_IRWE  = 7'b0001000;
    localparam logic [6:0] S_PCWE  = 7'b0000100;
    localparam logic [6:0] S_PCSEL = 7'b0000010;
    localparam logic [6:0] S_REGWE = 7'b0000001;

    typedef struct {
        logic       run;
        logic [6:0] op;
        logic       br;
        logic       rdy;
        logic [2:0] st;
        logic [6:0] stb;
        logic       halt;
        logic [1:0] cause;
        int         cyc;
        int         ret;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  ir_op;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        reg_we;
    logic        halted;
    logic [1:0]  trap_cause;
    logic [2:0]  state_o;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int nChecks = 0;
    int nFail   = 0;
    vec_t tbl[21];

    multicycle_sequencer #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .ir_op        (ir_op),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .halted       (halted),
        .trap_cause   (trap_cause),
        .state_o      (state_o),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [6:0] op, input logic br,
                                input logic rdy, input logic [2:0] st, input logic [6:0] stb,
                                input logic halt, input logic [1:0] cause,
                                input int cyc, input int ret);
        vec_t v;
        v.run = r; v.op = op; v.br = br; v.rdy = rdy; v.st = st; v.stb = stb;
        v.halt = halt; v.cause = cause; v.cyc = cyc; v.ret = ret;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        run       = v.run;
        ir_op     = v.op;
        br_taken  = v.br;
        mem_ready = v.rdy;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        logic [6:0] gotStb;
        gotStb = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we};
        cmp({tag, " state"}, int'(state_o), int'(v.st));
        nChecks++;
        if (gotStb !== v.stb) begin
            nFail++;
            $display("[TB] FAIL %s strobes: got %b, expected %b", tag, gotStb, v.stb);
        end
        cmp({tag, " halted"}, int'(halted), int'(v.halt));
        cmp({tag, " trap_cause"}, int'(trap_cause), int'(v.cause));
        cmp({tag, " cycle_cnt"}, int'(cycle_cnt), v.cyc);
        cmp({tag, " instret_cnt"}, int'(instret_cnt), v.ret);
    endtask

    // One clock per vector: drive just after the edge, check mid-cycle, then advance.
    task automatic doCycle(input vec_t v, input string tag);
        applyStimulus(v);
        #2;
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; ir_op = ADDI; br_taken = 1'b0; mem_ready = 1'b0;

        // addi, beq (taken), store, jal with memory always ready
        tbl[0]  = mk(1, ADDI,  0, 1, 0, 7'd0,                    0, 0, 0, 0);
        tbl[1]  = mk(1, ADDI,  0, 1, 1, S_REQ | S_IRWE,          0, 0, 0, 0);
        tbl[2]  = mk(1, ADDI,  0, 1, 2, 7'd0,                    0, 0, 1, 0);
        tbl[3]  = mk(1, ADDI,  0, 1, 3, 7'd0,                    0, 0, 2, 0);
        tbl[4]  = mk(1, ADDI,  0, 1, 5, S_REGWE | S_PCWE,        0, 0, 3, 0);
        tbl[5]  = mk(1, BEQ,   0, 1, 1, S_REQ | S_IRWE,          0, 0, 4, 1);
        tbl[6]  = mk(1, BEQ,   0, 1, 2, 7'd0,                    0, 0, 5, 1);
        tbl[7]  = mk(0, BEQ,   1, 1, 3, S_PCWE | S_PCSEL,        0, 0, 6, 1);
        tbl[8]  = mk(0, BEQ,   0, 1, 0, 7'd0,                    0, 0, 7, 2);
        tbl[9]  = mk(1, STORE, 0, 1, 0, 7'd0,                    0, 0, 7, 2);
        tbl[10] = mk(1, STORE, 0, 1, 1, S_REQ | S_IRWE,          0, 0, 7, 2);
        tbl[11] = mk(1, STORE, 0, 1, 2, 7'd0,                    0, 0, 8, 2);
        tbl[12] = mk(1, STORE, 0, 1, 3, 7'd0,                    0, 0, 9, 2);
        tbl[13] = mk(0, STORE, 0, 1, 4, S_REQ | S_WE | S_ASEL | S_PCWE, 0, 0, 10, 2);
        tbl[14] = mk(0, STORE, 0, 1, 0, 7'd0,                    0, 0, 11, 3);
        tbl[15] = mk(1, JAL,   0, 1, 0, 7'd0,                    0, 0, 11, 3);
        tbl[16] = mk(1, JAL,   0, 1, 1, S_REQ | S_IRWE,          0, 0, 11, 3);
        tbl[17] = mk(1, JAL,   0, 1, 2, 7'd0,                    0, 0, 12, 3);
        tbl[18] = mk(1, JAL,   0, 1, 3, 7'd0,                    0, 0, 13, 3);
        tbl[19] = mk(0, JAL,   0, 1, 5, S_REGWE | S_PCWE | S_PCSEL, 0, 0, 14, 3);
        tbl[20] = mk(0, JAL,   0, 1, 0, 7'd0,                    0, 0, 15, 4);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            doCycle(tbl[i], $sformatf("row%0d", i));
        end

        // Load with three stall cycles on both fetch and data; ready lands on the 4th cycle
        doCycle(mk(0, LOAD, 0, 1, 0, 7'd0,           0, 0, 15, 4), "ld idle-ready-ignored");
        doCycle(mk(1, LOAD, 0, 0, 0, 7'd0,           0, 0, 15, 4), "ld idle");
        doCycle(mk(1, LOAD, 0, 0, 1, S_REQ,          0, 0, 15, 4), "ld fwait1");
        doCycle(mk(1, LOAD, 0, 0, 1, S_REQ,          0, 0, 16, 4), "ld fwait2");
        doCycle(mk(1, LOAD, 0, 0, 1, S_REQ,          0, 0, 17, 4), "ld fwait3");
        doCycle(mk(1, LOAD, 0, 1, 1, S_REQ | S_IRWE, 0, 0, 18, 4), "ld fready");
        doCycle(mk(1, LOAD, 0, 1, 2, 7'd0,           0, 0, 19, 4), "ld decode");
        doCycle(mk(1, LOAD, 0, 1, 3, 7'd0,           0, 0, 20, 4), "ld exec");
        doCycle(mk(1, LOAD, 0, 0, 4, S_REQ | S_ASEL, 0, 0, 21, 4), "ld mwait1");
        doCycle(mk(1, LOAD, 0, 0, 4, S_REQ | S_ASEL, 0, 0, 22, 4), "ld mwait2");
        doCycle(mk(1, LOAD, 0, 0, 4, S_REQ | S_ASEL, 0, 0, 23, 4), "ld mwait3");
        doCycle(mk(1, LOAD, 0, 1, 4, S_REQ | S_ASEL, 0, 0, 24, 4), "ld mready");
        doCycle(mk(0, LOAD, 0, 1, 5, S_REGWE | S_PCWE, 0, 0, 25, 4), "ld wb");
        doCycle(mk(0, LOAD, 0, 1, 0, 7'd0,           0, 0, 26, 5), "ld done");

        // run drops during EXEC: instruction finishes, counters freeze in IDLE, then resume
        doCycle(mk(1, ADDI, 0, 1, 0, 7'd0,             0, 0, 26, 5), "rd idle");
        doCycle(mk(1, ADDI, 0, 1, 1, S_REQ | S_IRWE,   0, 0, 26, 5), "rd fetch");
        doCycle(mk(1, ADDI, 0, 1, 2, 7'd0,             0, 0, 27, 5), "rd decode");
        doCycle(mk(0, ADDI, 0, 1, 3, 7'd0,             0, 0, 28, 5), "rd exec");
        doCycle(mk(0, ADDI, 0, 1, 5, S_REGWE | S_PCWE, 0, 0, 29, 5), "rd wb");
        doCycle(mk(0, ADDI, 0, 1, 0, 7'd0,             0, 0, 30, 6), "rd idle1");
        doCycle(mk(0, ADDI, 0, 1, 0, 7'd0,             0, 0, 30, 6), "rd idle2");
        doCycle(mk(1, ADDI, 0, 1, 0, 7'd0,             0, 0, 30, 6), "rd resume");
        doCycle(mk(1, ADDI, 0, 1, 1, S_REQ | S_IRWE,   0, 0, 30, 6), "rd fetch2");
        doCycle(mk(1, ADDI, 0, 1, 2, 7'd0,             0, 0, 31, 6), "rd decode2");
        doCycle(mk(1, ADDI, 0, 1, 3, 7'd0,             0, 0, 32, 6), "rd exec2");
        doCycle(mk(0, ADDI, 0, 1, 5, S_REGWE | S_PCWE, 0, 0, 33, 6), "rd wb2");
        doCycle(mk(0, ADDI, 0, 1, 0, 7'd0,             0, 0, 34, 7), "rd done");

        // Reset while a fetch is pending drops mem_req on the next edge
        resetDut();
        doCycle(mk(1, ADDI, 0, 0, 0, 7'd0,  0, 0, 0, 0), "rp idle");
        doCycle(mk(1, ADDI, 0, 0, 1, S_REQ, 0, 0, 0, 0), "rp fetch");
        rst_n = 1'b0;
        doCycle(mk(1, ADDI, 0, 0, 1, S_REQ, 0, 0, 1, 0), "rp fetch-rst");
        rst_n = 1'b1;
        doCycle(mk(0, ADDI, 0, 0, 0, 7'd0,  0, 0, 0, 0), "rp after");

        // Fetch timeout: four cycles without mem_ready
        doCycle(mk(1, ADDI, 0, 0, 0, 7'd0,  0, 0, 0, 0), "ft idle");
        doCycle(mk(1, ADDI, 0, 0, 1, S_REQ, 0, 0, 0, 0), "ft wait1");
        doCycle(mk(1, ADDI, 0, 0, 1, S_REQ, 0, 0, 1, 0), "ft wait2");
        doCycle(mk(1, ADDI, 0, 0, 1, S_REQ, 0, 0, 2, 0), "ft wait3");
        doCycle(mk(1, ADDI, 0, 0, 1, S_REQ, 0, 0, 3, 0), "ft wait4");
        doCycle(mk(1, ADDI, 0, 1, 6, 7'd0,  1, 2, 4, 0), "ft trap");
        doCycle(mk(1, ADDI, 0, 1, 6, 7'd0,  1, 2, 4, 0), "ft trap-hold");

        // Data-phase timeout on a store: no pc_we, no retire
        resetDut();
        doCycle(mk(1, STORE, 0, 1, 0, 7'd0,                 0, 0, 0, 0), "mt idle");
        doCycle(mk(1, STORE, 0, 1, 1, S_REQ | S_IRWE,       0, 0, 0, 0), "mt fetch");
        doCycle(mk(1, STORE, 0, 1, 2, 7'd0,                 0, 0, 1, 0), "mt decode");
        doCycle(mk(1, STORE, 0, 1, 3, 7'd0,                 0, 0, 2, 0), "mt exec");
        doCycle(mk(1, STORE, 0, 0, 4, S_REQ | S_WE | S_ASEL, 0, 0, 3, 0), "mt wait1");
        doCycle(mk(1, STORE, 0, 0, 4, S_REQ | S_WE | S_ASEL, 0, 0, 4, 0), "mt wait2");
        doCycle(mk(1, STORE, 0, 0, 4, S_REQ | S_WE | S_ASEL, 0, 0, 5, 0), "mt wait3");
        doCycle(mk(1, STORE, 0, 0, 4, S_REQ | S_WE | S_ASEL, 0, 0, 6, 0), "mt wait4");
        doCycle(mk(1, STORE, 0, 1, 6, 7'd0,                 1, 2, 7, 0), "mt trap");

        // Illegal opcode traps after DECODE and stays quiet until reset
        resetDut();
        doCycle(mk(1, BAD, 0, 1, 0, 7'd0,           0, 0, 0, 0), "il idle");
        doCycle(mk(1, BAD, 0, 1, 1, S_REQ | S_IRWE, 0, 0, 0, 0), "il fetch");
        doCycle(mk(1, BAD, 1, 1, 2, 7'd0,           0, 0, 1, 0), "il decode");
        for (int i = 0; i < 21; i++) begin
            doCycle(mk(1, BAD, 1, 1, 6, 7'd0, 1, 1, 2, 0), $sformatf("il trap%0d", i));
        end
        resetDut();
        doCycle(mk(0, BAD, 0, 1, 0, 7'd0, 0, 0, 0, 0), "il after-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle sequencer for the RV32I datapath: walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the memory handshake and the IR/PC/register-file write enables. The existing combinational decoder supplies the per-instruction datapath selects (immSel, ALUSel, Asel, Bsel, WBSel, PCSel). This block decides *when* state is committed. It also keeps the cycle and retired-instruction counters and traps on illegal opcodes or memory timeouts.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for mem_ready per memory access; must be ≥1.
- CNT_W, 32: width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- run  in  1  enable; sampled only at instruction boundaries.
- ir_op  in  7  opcode field of the instruction register (ir[6:0]).
- br_taken  in  1  branch-taken decision (decoder PCSel), valid in EXEC.
- mem_ready  in  1  memory completion strobe.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store, 0 = read.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data).
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC update.
- pc_sel  out  1  0 = PC+4, 1 = ALU target.
- reg_we  out  1  register-file write.
- halted  out  1  in TRAP.
- trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout.
- state_o  out  3  current state encoding.
- cycle_cnt  out  CNT_W  active cycles.
- instret_cnt  out  CNT_W  retired instructions.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Instruction classes from ir_op:
  - LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111 (class JUMP).
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111 (class ALU).
  - Any other opcode is illegal.
- Transitions:
  - IDLE: run=1 → FETCH.
  - FETCH: mem_req=1, mem_addr_sel=0. On mem_ready, ir_we=1 → DECODE.
  - DECODE: illegal → TRAP (cause 1); otherwise → EXEC.
  - EXEC, LOAD/STORE: → MEM.
  - EXEC, BRANCH: pc_we=1, pc_sel=br_taken, retire, then go to the boundary.
  - EXEC, ALU/JUMP: → WB.
  - MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE).
  - MEM, on mem_ready with LOAD: → WB.
  - MEM, on mem_ready with STORE: pc_we=1, pc_sel=0, retire, then go to the boundary.
  - WB: reg_we=1, pc_we=1, pc_sel=(JUMP), retire, then go to the boundary.
  - Boundary: run=1 → FETCH; run=0 → IDLE.
  - TRAP: absorbing. halted=1, cause held, all enables 0. Exited only by reset.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable from request until the cycle mem_ready=1. The access completes in that cycle.
  - mem_ready while mem_req=0 is ignored.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments on each cycle without mem_ready. The MEM_TIMEOUT-th consecutive cycle without mem_ready → TRAP (cause 2), with no ir_we or pc_we.
- Counters:
  - cycle_cnt increments in every state except IDLE and TRAP.
  - instret_cnt increments on each retire cycle.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset values: state=IDLE, all enables 0, halted=0, trap_cause=0, both counters 0, wait counter 0.
- state_o, halted, trap_cause and the counters are registered.
- Strobes are combinational from state, qualified by mem_ready where stated. ir_we, and pc_we in MEM, are single-cycle and coincide with mem_ready.
- Latency with mem_ready already high on each request cycle:
  - ALU/JUMP: 4 cycles.
  - BRANCH: 3 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Each memory wait cycle adds 1.
- run falling mid-instruction: the instruction completes and the sequencer goes to IDLE at the boundary. No partial commit.
- Reset during a pending access drops mem_req on the next edge. Memory must discard the access.
- mem_ready on the same cycle the timeout would expire: the access completes and there is no trap.

## Structure
- Package rv_seq_pkg holds:
  - The state enum with its encodings.
  - The opcode constants.
  - The class enum (LOAD, STORE, BRANCH, JUMP, ALU, ILLEGAL).
  - The trap_cause codes.
- Sub-module rv_op_classify: combinational ir_op → class. The main FSM plus counters sit in multicycle_sequencer.

## Test plan
- ALU then branch, run=1, mem_ready tied 1. Instructions: 0x00500093 (addi) then 0x00000463 (beq) with br_taken=1. Required:
  - addi: states 1,2,3,5, with reg_we then pc_we/pc_sel=0 in WB.
  - beq: 1,2,3, with pc_we=1, pc_sel=1 in EXEC.
  - instret_cnt=2, cycle_cnt=7.
- Load with mem_ready delayed 3 cycles on fetch and on data. Required:
  - mem_req and mem_addr_sel stable while waiting.
  - ir_we only on the fetch ready cycle; reg_we once, in WB.
  - 11 cycles total.
- Store 0x0020A023: mem_we=1, mem_addr_sel=1 in MEM; no reg_we; pc_we with pc_sel=0 on the ready cycle; instret +1.
- ir_op=0x7F → TRAP after DECODE, with trap_cause=1, halted=1. Every strobe stays 0 for 20 further cycles until rst_n=0 returns the sequencer to IDLE.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH → TRAP on the 4th wait cycle, cause 2. A repeat test with mem_ready arriving on the 4th cycle completes normally.
- run drops during EXEC of an ALU op: WB completes, state goes to IDLE, cycle_cnt freezes; run=1 resumes with FETCH.
